// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states
// and instruction field positions.
package cpu_pkg;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_MVNZ = 4'd8;
    localparam logic [3:0] OP_LD   = 4'd9;
    localparam logic [3:0] OP_SD   = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd11;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RX_HI  = 11;
    localparam int RX_LO  = 9;
    localparam int RY_HI  = 8;
    localparam int RY_LO  = 6;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EX1,
        S_EX2,
        S_EX3,
        S_HALT
    } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multi-cycle core.
// Shift amounts use the low log2(DATA_W) bits of b.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] amt;

    assign amt = b[SH_W-1:0];

    // Shifting by amt >= DATA_W yields zero by language semantics.
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_SLT:  y = DATA_W'(a < b);
            OP_SLL:  y = a << amt;
            OP_SRL:  y = a >> amt;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/param_multicycle_cpu.sv
// Parametrised multi-cycle 16-bit-instruction processor core.
// FSM, register file, memories and PC live here; arithmetic in cpu_alu.
module param_multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 8
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Run,
    input  logic                          IWrEn,
    input  logic [$clog2(IMEM_DEPTH)-1:0] IWrAddr,
    input  logic [15:0]                   IWrData,
    output logic                          Done,
    output logic                          Halted,
    output logic [DATA_W-1:0]             Out,
    output logic [$clog2(IMEM_DEPTH)-1:0] Pc
);

    localparam int IA_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);

    state_t state;
    state_t state_nxt;

    logic [15:0]       ir;
    logic [15:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];
    logic [DATA_W-1:0] rf [8];
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] g_reg;
    logic              g_nz;
    logic [DA_W-1:0]   daddr;

    logic [3:0]        op;
    logic [2:0]        rx;
    logic [2:0]        ry;
    logic [DATA_W-1:0] rx_v;
    logic [DATA_W-1:0] ry_v;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_y;

    logic              retire;
    logic              rf_we;
    logic              out_we;
    logic              a_ld;
    logic              g_ld;
    logic              addr_ld;
    logic              mem_we;
    logic              halt_set;
    logic [DATA_W-1:0] rf_wd;

    assign op    = ir[OP_HI:OP_LO];
    assign rx    = ir[RX_HI:RX_LO];
    assign ry    = ir[RY_HI:RY_LO];
    assign rx_v  = rf[rx];
    assign ry_v  = rf[ry];
    assign alu_a = (state == S_EX2) ? a_reg : rx_v;

    cpu_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op(op),
        .a (alu_a),
        .b (ry_v),
        .y (alu_y)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        rf_we     = 1'b0;
        out_we    = 1'b0;
        a_ld      = 1'b0;
        g_ld      = 1'b0;
        addr_ld   = 1'b0;
        mem_we    = 1'b0;
        halt_set  = 1'b0;
        rf_wd     = alu_y;
        case (state)
            S_IDLE:  if (Run) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_EX1;
            S_EX1: begin
                case (op)
                    OP_MV: begin
                        rf_wd  = ry_v;
                        rf_we  = 1'b1;
                        out_we = 1'b1;
                        retire = 1'b1;
                    end
                    OP_MVI: begin
                        rf_wd  = DATA_W'(ir[RY_HI:IMM_LO]);
                        rf_we  = 1'b1;
                        out_we = 1'b1;
                        retire = 1'b1;
                    end
                    OP_AND, OP_SLT, OP_SLL, OP_SRL: begin
                        rf_we  = 1'b1;
                        out_we = 1'b1;
                        retire = 1'b1;
                    end
                    // Writing rX back to itself is the "no write" case.
                    OP_MVNZ: begin
                        rf_wd  = g_nz ? ry_v : rx_v;
                        rf_we  = 1'b1;
                        out_we = 1'b1;
                        retire = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        a_ld      = 1'b1;
                        state_nxt = S_EX2;
                    end
                    OP_LD, OP_SD: begin
                        addr_ld   = 1'b1;
                        state_nxt = S_EX2;
                    end
                    OP_HALT: begin
                        halt_set = 1'b1;
                        retire   = 1'b1;
                    end
                    default: retire = 1'b1;
                endcase
            end
            S_EX2: begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        g_ld      = 1'b1;
                        state_nxt = S_EX3;
                    end
                    OP_LD: begin
                        rf_wd  = dmem[daddr];
                        rf_we  = 1'b1;
                        out_we = 1'b1;
                        retire = 1'b1;
                    end
                    OP_SD: begin
                        rf_wd  = rx_v;
                        mem_we = 1'b1;
                        out_we = 1'b1;
                        retire = 1'b1;
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
            S_EX3: begin
                rf_wd  = g_reg;
                rf_we  = 1'b1;
                out_we = 1'b1;
                retire = 1'b1;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
        if (retire) begin
            if (halt_set)  state_nxt = S_HALT;
            else if (Run)  state_nxt = S_FETCH;
            else           state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Pc     <= '0;
            ir     <= '0;
            Done   <= 1'b0;
            Halted <= 1'b0;
            Out    <= '0;
            g_nz   <= 1'b0;
            a_reg  <= '0;
            g_reg  <= '0;
            daddr  <= '0;
            for (int i = 0; i < 8; i++) rf[i] <= DATA_W'(i);
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= DATA_W'(i);
        end else begin
            Done <= retire;
            if (state == S_FETCH) begin
                ir <= imem[Pc];
                Pc <= Pc + IA_W'(1);
            end
            if (a_ld) a_reg <= rx_v;
            if (g_ld) begin
                g_reg <= alu_y;
                g_nz  <= (alu_y != '0);
            end
            if (addr_ld)  daddr      <= ry_v[DA_W-1:0];
            if (rf_we)    rf[rx]     <= rf_wd;
            if (mem_we)   dmem[daddr] <= rx_v;
            if (out_we)   Out        <= rf_wd;
            if (halt_set) Halted     <= 1'b1;
        end
    end

    // Program memory is loadable only while the core is not executing.
    always_ff @(posedge Clock) begin
        if (IWrEn && (state == S_IDLE || state == S_HALT))
            imem[IWrAddr] <= IWrData;
    end

endmodule

// File: tb/tb_param_multicycle_cpu.sv
// Scoreboard bench for param_multicycle_cpu: stimulus queues expected
// retirements (Out, Pc, cycle); a monitor pops one per Done pulse.
module tb_param_multicycle_cpu;
    import cpu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Run;
    logic        IWrEn;
    logic [3:0]  IWrAddr;
    logic [15:0] IWrData;
    logic        Done;
    logic        Halted;
    logic [15:0] Out;
    logic [3:0]  Pc;

    typedef struct {
        logic [15:0] out;
        logic [3:0]  pc;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   t_exp = 0;
    int   e0;

    param_multicycle_cpu #(
        .DATA_W(16),
        .IMEM_DEPTH(16),
        .DMEM_DEPTH(8)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Run    (Run),
        .IWrEn  (IWrEn),
        .IWrAddr(IWrAddr),
        .IWrData(IWrData),
        .Done   (Done),
        .Halted (Halted),
        .Out    (Out),
        .Pc     (Pc)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (Done) begin
            n_total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_done: Out=%h Pc=%0d cyc=%0d, no retire expected",
                         Out, Pc, cyc);
            end else begin
                e = q.pop_front();
                if (Out === e.out && Pc === e.pc && cyc == e.cyc)
                    n_pass++;
                else
                    $display("FAIL retire: Out=%h Pc=%0d cyc=%0d, want Out=%h Pc=%0d cyc=%0d",
                             Out, Pc, cyc, e.out, e.pc, e.cyc);
            end
        end
    end

    function automatic logic [15:0] enc(int op, int rx, int ry);
        return {op[3:0], rx[2:0], ry[2:0], 6'd0};
    endfunction

    function automatic logic [15:0] enc_i(int op, int rx, int imm);
        return {op[3:0], rx[2:0], imm[8:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, want);
    endtask

    task automatic wait_until(int n);
        while (cyc < n) @(negedge Clock);
    endtask

    task automatic load(int a, logic [15:0] w);
        IWrEn   = 1'b1;
        IWrAddr = 4'(a);
        IWrData = w;
        @(negedge Clock);
        IWrEn   = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Run   = 1'b0;
        IWrEn = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic start_run();
        Run   = 1'b1;
        t_exp = cyc + 1;
    endtask

    task automatic push(logic [15:0] out, logic [3:0] pc, int lat);
        exp_t x;
        t_exp += lat;
        x.out = out;
        x.pc  = pc;
        x.cyc = t_exp;
        q.push_back(x);
    endtask

    task automatic finish_prog(string name);
        wait_until(t_exp + 4);
        Run = 1'b0;
        chk({name, "_drain"}, q.size(), 0);
        q.delete();
    endtask

    initial begin
        Reset   = 1'b1;
        Run     = 1'b0;
        IWrEn   = 1'b0;
        IWrAddr = '0;
        IWrData = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("rst_done", Done, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_out", Out, 0);
        chk("rst_pc", Pc, 0);

        // mvi then halt
        load(0, enc_i(OP_MVI, 2, 5));
        load(1, enc(OP_HALT, 0, 0));
        start_run();
        push(16'h5, 4'd1, 2);
        push(16'h5, 4'd2, 2);
        finish_prog("t1");
        chk("t1_halted", Halted, 1);

        // add/sub/mvnz, flag, wrap, rX==rY, nop, mv
        do_reset();
        chk("t2_halted_clr", Halted, 0);
        load(0, enc_i(OP_MVI, 2, 5));
        load(1, enc(OP_ADD, 2, 3));
        load(2, enc(OP_SUB, 4, 4));
        load(3, enc(OP_MVNZ, 1, 0));
        load(4, enc(OP_SUB, 0, 7));
        load(5, enc(OP_MVNZ, 6, 2));
        load(6, enc(OP_ADD, 2, 2));
        load(7, enc(12, 0, 0));
        load(8, enc(OP_MV, 3, 0));
        load(9, enc(OP_HALT, 0, 0));
        start_run();
        push(16'h0005, 4'd1, 2);
        push(16'h0008, 4'd2, 4);
        push(16'h0000, 4'd3, 4);
        push(16'h0001, 4'd4, 2);
        push(16'hFFF9, 4'd5, 4);
        push(16'h0008, 4'd6, 2);
        push(16'h0010, 4'd7, 4);
        push(16'h0010, 4'd8, 2);
        push(16'hFFF9, 4'd9, 2);
        push(16'hFFF9, 4'd10, 2);
        finish_prog("t2");

        // memory and logic/shift ops
        do_reset();
        load(0, enc_i(OP_MVI, 5, 'hAB));
        load(1, enc_i(OP_MVI, 6, 9));
        load(2, enc(OP_SD, 5, 6));
        load(3, enc(OP_LD, 7, 6));
        load(4, enc(OP_LD, 0, 3));
        load(5, enc(OP_AND, 3, 4));
        load(6, enc(OP_SLT, 2, 4));
        load(7, enc(OP_SLT, 7, 2));
        load(8, enc(OP_SLL, 4, 4));
        load(9, enc(OP_SRL, 4, 2));
        load(10, enc_i(OP_MVI, 1, 'h1F1));
        load(11, enc(OP_SLL, 4, 1));
        load(12, enc(OP_HALT, 0, 0));
        start_run();
        push(16'h00AB, 4'd1, 2);
        push(16'h0009, 4'd2, 2);
        push(16'h00AB, 4'd3, 3);
        push(16'h00AB, 4'd4, 3);
        push(16'h0003, 4'd5, 3);
        push(16'h0000, 4'd6, 2);
        push(16'h0001, 4'd7, 2);
        push(16'h0000, 4'd8, 2);
        push(16'h0040, 4'd9, 2);
        push(16'h0020, 4'd10, 2);
        push(16'h01F1, 4'd11, 2);
        push(16'h0040, 4'd12, 2);
        push(16'h0040, 4'd13, 2);
        finish_prog("t3");

        // full IMEM, PC wrap, Run drop in EX1 of the 17th
        do_reset();
        for (int k = 0; k < 16; k++) load(k, enc_i(OP_MVI, 1, 64 + k));
        start_run();
        e0 = t_exp;
        for (int k = 0; k < 16; k++) push(16'(64 + k), 4'(k + 1), 2);
        push(16'h0040, 4'd1, 2);
        wait_until(e0 + 33);
        Run = 1'b0;
        finish_prog("t4");
        chk("t4_pc_idle", Pc, 1);

        // Run drop in EX2 of add; IMEM writes in IDLE vs executing
        do_reset();
        load(0, enc(OP_ADD, 2, 3));
        load(1, enc_i(OP_MVI, 1, 'h11));
        load(2, enc_i(OP_MVI, 1, 'h22));
        load(3, enc(OP_HALT, 0, 0));
        start_run();
        e0 = t_exp;
        push(16'h0005, 4'd1, 4);
        wait_until(e0 + 2);
        Run = 1'b0;
        wait_until(e0 + 8);
        chk("t5_pc_idle", Pc, 1);
        chk("t5_out_idle", Out, 16'h0005);
        chk("t5a_drain", q.size(), 0);
        load(1, enc_i(OP_MVI, 1, 'h33));
        start_run();
        e0 = t_exp;
        push(16'h0033, 4'd2, 2);
        push(16'h0022, 4'd3, 2);
        push(16'h0022, 4'd4, 2);
        wait_until(e0 + 1);
        load(2, enc_i(OP_MVI, 1, 'h77));
        finish_prog("t5");
        chk("t5_halted", Halted, 1);

        // async reset while add sits in EX2
        do_reset();
        load(0, enc_i(OP_MVI, 1, 9));
        load(1, enc(OP_ADD, 2, 3));
        start_run();
        e0 = t_exp;
        push(16'h0009, 4'd1, 2);
        wait_until(e0 + 4);
        Reset = 1'b1;
        Run   = 1'b0;
        #1;
        chk("t6_rst_pc", Pc, 0);
        chk("t6_rst_out", Out, 0);
        chk("t6_rst_done", Done, 0);
        chk("t6a_drain", q.size(), 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        load(0, enc(OP_MV, 1, 2));
        load(1, enc(OP_HALT, 0, 0));
        start_run();
        push(16'h0002, 4'd1, 2);
        push(16'h0002, 4'd2, 2);
        finish_prog("t6");
        chk("t6_halted", Halted, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
